// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// ---------------------------------------------------------------------------
// tt_um_jleugeri_ttt_scheduler
//
// Purpose: host-driven scheduler for a bank of token-processing processor
// contexts. Each "step" updates every processor once, in ascending id order,
// and collects the start/stop events they report into a small FIFO. The
// events are then streamed to the host. For each accepted event, a
// network lookup is run whose results are fed back to the processors as
// token injections.
//
// Ports (all logic runs on posedge clock_fast, reset is synchronous/active-high):
//   clock_fast, reset         clock and reset
//   cmd / cmd_ready           host command (00 idle, 01 inject, 10 step, 11 no-op),
//                             accepted only while cmd_ready (IDLE)
//   in_id, in_good, in_bad    injection target and signed token deltas
//   proc_instr, proc_id,      processor command bus (000 nop, 001 inject,
//   proc_good, proc_bad       010 update)
//   proc_startstop            {start,stop} of the processor updated last cycle
//   net_instr, net_source_id  network command (000 nop, 010 start, 011 continue)
//   net_done, net_valid,      network responses
//   net_target_id,
//   net_good, net_bad
//   ev_valid/ev_ready,        host event stream (valid/ready handshake)
//   ev_id, ev_startstop
//   stage                     current state (00 IDLE, 01 UPDATE, 10 DRAIN, 11 ROUTE)
//   overflow                  sticky flag: an event was dropped on a full FIFO
//
// Build option: define TTT_SCHED_EVENT_COUNT_EN to add the 16-bit output
// event_count, a saturating count of event-stream handshakes.
// ---------------------------------------------------------------------------
module tt_um_jleugeri_ttt_scheduler #(
    parameter int NUM_PROCESSORS = 16,
    parameter int NEW_TOKEN_BITS = 4,
    parameter int FIFO_DEPTH     = 8,
    localparam int PW = $clog2(NUM_PROCESSORS),
    localparam int B  = NEW_TOKEN_BITS
) (
    input  logic                clock_fast,
    input  logic                reset,
    input  logic [1:0]          cmd,
    output logic                cmd_ready,
    input  logic [PW-1:0]       in_id,
    input  logic signed [B-1:0] in_good,
    input  logic signed [B-1:0] in_bad,
    output logic [2:0]          proc_instr,
    output logic [PW-1:0]       proc_id,
    output logic signed [B-1:0] proc_good,
    output logic signed [B-1:0] proc_bad,
    input  logic [1:0]          proc_startstop,
    output logic [2:0]          net_instr,
    output logic [PW-1:0]       net_source_id,
    input  logic                net_done,
    input  logic                net_valid,
    input  logic [PW-1:0]       net_target_id,
    input  logic signed [B-1:0] net_good,
    input  logic signed [B-1:0] net_bad,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [PW-1:0]       ev_id,
    output logic [1:0]          ev_startstop,
    output logic [1:0]          stage,
    output logic                overflow
`ifdef TTT_SCHED_EVENT_COUNT_EN
    ,
    output logic [15:0]         event_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UPDATE = 2'b01,
        DRAIN  = 2'b10,
        ROUTE  = 2'b11
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] LAST_C = (PW+1)'(NUM_PROCESSORS - 1);
    localparam logic [PW:0] N_C    = (PW+1)'(NUM_PROCESSORS);
    localparam logic signed [B-1:0] TOK_MIN = {1'b1, {(B-1){1'b0}}};
    localparam logic signed [B-1:0] TOK_MAX = {1'b0, {(B-1){1'b1}}};

    // Negation that maps the most negative value onto the most positive one
    // instead of wrapping back onto itself.
    function automatic logic signed [B-1:0] neg_sat(input logic signed [B-1:0] v);
        logic signed [B-1:0] r;
        if (v == TOK_MIN) begin
            r = TOK_MAX;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    state_t                state_q;
    logic [PW:0]           cnt_q;       // UPDATE cycle index 0..N
    logic                  first_q;     // first ROUTE cycle (net_valid ignored)
    logic                  sign_q;      // 1: pass network values, 0: negate them
    logic [PW+1:0]         fifo_q [FIFO_DEPTH];   // {id, startstop}
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  overflow_q;
    logic [2:0]            proc_instr_q;
    logic [PW-1:0]         proc_id_q;
    logic signed [B-1:0]   proc_good_q;
    logic signed [B-1:0]   proc_bad_q;
    logic [2:0]            net_instr_q;
    logic [PW-1:0]         net_src_q;

    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [PW+1:0]         head_s;
    logic                  push_s;
    logic                  ev_valid_s;

    // FIFO status, head entry and event-push qualification.
    always_comb begin
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_s       = fifo_q[rd_ptr_q[AW-1:0]];
        // Cycle 0 has no processor result yet; 00/11 are not events.
        push_s       = (state_q == UPDATE) && (cnt_q != '0) &&
                       ((proc_startstop == 2'b01) || (proc_startstop == 2'b10));
        ev_valid_s   = (state_q == DRAIN) && !fifo_empty_s;
    end

    // Scheduler FSM, event FIFO and registered command outputs.
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            sign_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            proc_instr_q <= 3'b000;
            proc_id_q    <= '0;
            proc_good_q  <= '0;
            proc_bad_q   <= '0;
            net_instr_q  <= 3'b000;
            net_src_q    <= '0;
        end else begin
            if (push_s) begin
                if (fifo_full_s) begin
                    overflow_q <= 1'b1;
                end else begin
                    // Result belongs to the processor updated one cycle earlier.
                    fifo_q[wr_ptr_q[AW-1:0]] <= {cnt_q[PW-1:0] - PW'(1), proc_startstop};
                    wr_ptr_q                 <= wr_ptr_q + (AW+1)'(1);
                end
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end

            case (state_q)
                IDLE: begin
                    net_instr_q <= 3'b000;
                    case (cmd)
                        2'b01: begin
                            proc_instr_q <= 3'b001;
                            proc_id_q    <= in_id;
                            proc_good_q  <= in_good;
                            proc_bad_q   <= in_bad;
                        end
                        2'b10: begin
                            state_q      <= UPDATE;
                            cnt_q        <= '0;
                            proc_instr_q <= 3'b010;
                            proc_id_q    <= '0;
                            proc_good_q  <= '0;
                            proc_bad_q   <= '0;
                        end
                        default: begin
                            proc_instr_q <= 3'b000;
                            proc_id_q    <= '0;
                            proc_good_q  <= '0;
                            proc_bad_q   <= '0;
                        end
                    endcase
                end
                UPDATE: begin
                    cnt_q <= cnt_q + (PW+1)'(1);
                    if (cnt_q < LAST_C) begin
                        proc_instr_q <= 3'b010;
                        proc_id_q    <= cnt_q[PW-1:0] + PW'(1);
                    end else begin
                        proc_instr_q <= 3'b000;
                        proc_id_q    <= '0;
                    end
                    if (cnt_q == N_C) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q <= UPDATE;
                    end
                end
                DRAIN: begin
                    proc_instr_q <= 3'b000;
                    if (fifo_empty_s) begin
                        state_q     <= IDLE;
                        net_instr_q <= 3'b000;
                    end else if (ev_ready) begin
                        rd_ptr_q    <= rd_ptr_q + (AW+1)'(1);
                        sign_q      <= head_s[1];
                        net_src_q   <= head_s[PW+1:2];
                        net_instr_q <= 3'b010;
                        first_q     <= 1'b1;
                        state_q     <= ROUTE;
                    end else begin
                        net_instr_q <= 3'b000;
                    end
                end
                ROUTE: begin
                    first_q <= 1'b0;
                    if (net_done) begin
                        net_instr_q  <= 3'b000;
                        proc_instr_q <= 3'b000;
                        state_q      <= DRAIN;
                    end else begin
                        net_instr_q <= 3'b011;
                        if (!first_q && net_valid) begin
                            proc_instr_q <= 3'b001;
                            proc_id_q    <= net_target_id;
                            proc_good_q  <= sign_q ? net_good : neg_sat(net_good);
                            proc_bad_q   <= sign_q ? net_bad  : neg_sat(net_bad);
                        end else begin
                            proc_instr_q <= 3'b000;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TTT_SCHED_EVENT_COUNT_EN
    logic [15:0] event_count_q;

    // Saturating count of accepted events.
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            event_count_q <= 16'd0;
        end else if (ev_valid_s && ev_ready && (event_count_q != 16'hFFFF)) begin
            event_count_q <= event_count_q + 16'd1;
        end else begin
            event_count_q <= event_count_q;
        end
    end

    assign event_count = event_count_q;
`endif

    assign cmd_ready     = (state_q == IDLE);
    assign stage         = state_q;
    assign overflow      = overflow_q;
    assign ev_valid      = ev_valid_s;
    assign ev_id         = head_s[PW+1:2];
    assign ev_startstop  = head_s[1:0];
    assign proc_instr    = proc_instr_q;
    assign proc_id       = proc_id_q;
    assign proc_good     = proc_good_q;
    assign proc_bad      = proc_bad_q;
    assign net_instr     = net_instr_q;
    assign net_source_id = net_src_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Testbench for tt_um_jleugeri_ttt_scheduler (N=4 processors, 4-bit tokens,
// 2-deep event FIFO). Directed scenarios followed by randomized rounds, all
// checked against an event-list model kept in the bench.
module tb_tt_um_jleugeri_ttt_scheduler;

    localparam int N = 4;
    localparam int B = 4;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic [1:0] in_id;
    logic [3:0] in_good, in_bad;
    logic [2:0] proc_instr;
    logic [1:0] proc_id;
    logic [3:0] proc_good, proc_bad;
    logic [1:0] proc_startstop;
    logic [2:0] net_instr;
    logic [1:0] net_source_id;
    logic       net_done, net_valid;
    logic [1:0] net_target_id;
    logic [3:0] net_good, net_bad;
    logic       ev_valid, ev_ready;
    logic [1:0] ev_id, ev_startstop;
    logic [1:0] stage;
    logic       overflow;
`ifdef TTT_SCHED_EVENT_COUNT_EN
    logic [15:0] event_count;
`endif

    always #5 clk = ~clk;

    tt_um_jleugeri_ttt_scheduler #(
        .NUM_PROCESSORS(N), .NEW_TOKEN_BITS(B), .FIFO_DEPTH(D)
    ) dut (
        .clock_fast(clk), .reset(reset), .cmd(cmd), .cmd_ready(cmd_ready),
        .in_id(in_id), .in_good(in_good), .in_bad(in_bad),
        .proc_instr(proc_instr), .proc_id(proc_id), .proc_good(proc_good),
        .proc_bad(proc_bad), .proc_startstop(proc_startstop),
        .net_instr(net_instr), .net_source_id(net_source_id),
        .net_done(net_done), .net_valid(net_valid), .net_target_id(net_target_id),
        .net_good(net_good), .net_bad(net_bad),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
        .ev_startstop(ev_startstop), .stage(stage), .overflow(overflow)
`ifdef TTT_SCHED_EVENT_COUNT_EN
        , .event_count(event_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: pending events (ascending id) and sticky overflow.
    int         q_id[$];
    logic [1:0] q_ss[$];
    bit         exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Token the processor should receive: pass or negate, clamped to +7.
    function automatic logic [3:0] exp_tok(input logic [3:0] raw, input bit sgn);
        int v;
        int r;
        v = $signed(raw);
        r = sgn ? v : -v;
        if (r > 7) r = 7;
        return r[3:0];
    endfunction

    task automatic chk_reset_state();
        chk("rst_stage", stage, 2'b00);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_proc_instr", proc_instr, 3'b000);
        chk("rst_proc_id", proc_id, 2'b00);
        chk("rst_proc_good", proc_good, 4'h0);
        chk("rst_proc_bad", proc_bad, 4'h0);
        chk("rst_net_instr", net_instr, 3'b000);
        chk("rst_net_src", net_source_id, 2'b00);
`ifdef TTT_SCHED_EVENT_COUNT_EN
        chk("rst_event_count", event_count, 16'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_id.delete();
        q_ss.delete();
        exp_ovf = 1'b0;
        chk_reset_state();
    endtask

    task automatic inject(input logic [1:0] id, input logic [3:0] g, input logic [3:0] b);
        cmd = 2'b01; in_id = id; in_good = g; in_bad = b;
        tick();
        cmd = 2'b00;
        chk("inj_instr", proc_instr, 3'b001);
        chk("inj_id", proc_id, id);
        chk("inj_good", proc_good, g);
        chk("inj_bad", proc_bad, b);
        chk("inj_stage", stage, 2'b00);
        tick();
        chk("inj_idle_instr", proc_instr, 3'b000);
    endtask

    // One step; ssv[2k+:2] is the {start,stop} answer of processor k.
    task automatic do_step(input logic [7:0] ssv);
        logic [1:0] s;
        cmd = 2'b10;
        tick();
        for (int c = 0; c <= N; c++) begin
            chk("upd_stage", stage, 2'b01);
            chk("upd_cmd_ready", cmd_ready, 1'b0);
            if (c < N) begin
                chk("upd_instr", proc_instr, 3'b010);
                chk("upd_id", proc_id, c);
                chk("upd_good", proc_good, 4'h0);
            end else begin
                chk("upd_last_instr", proc_instr, 3'b000);
            end
            cmd = 2'($urandom);
            in_id = 2'($urandom);
            in_good = 4'($urandom);
            if (c == 0) begin
                proc_startstop = 2'($urandom);
            end else begin
                s = ssv[2*(c-1) +: 2];
                proc_startstop = s;
                if (s == 2'b01 || s == 2'b10) begin
                    if (q_id.size() < D) begin
                        q_id.push_back(c - 1);
                        q_ss.push_back(s);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
            tick();
        end
        cmd = 2'b00;
        proc_startstop = 2'($urandom);
        chk("step_drain_stage", stage, 2'b10);
        chk("step_overflow", overflow, exp_ovf);
    endtask

    task automatic route_one(input bit sgn, input bit force_min);
        logic [2:0] e_pi;
        logic [1:0] e_id;
        logic [3:0] e_g, e_b;
        int nres;
        bit v;
        e_pi = 3'b000; e_id = 2'b00; e_g = 4'h0; e_b = 4'h0;
        net_valid = 1'($urandom);
        net_target_id = 2'($urandom);
        net_good = 4'($urandom);
        net_bad = 4'($urandom);
        if (!force_min && $urandom_range(0, 7) == 0) begin
            net_done = 1'b1;
            tick();
            net_done = 1'b0; net_valid = 1'b0;
            chk("early_done_stage", stage, 2'b10);
            chk("early_done_net", net_instr, 3'b000);
            chk("early_done_proc", proc_instr, 3'b000);
            return;
        end
        tick();
        nres = force_min ? 1 : $urandom_range(0, 4);
        for (int r = 0; r <= nres; r++) begin
            chk("route_stage", stage, 2'b11);
            chk("route_net", net_instr, 3'b011);
            chk("route_proc_instr", proc_instr, e_pi);
            if (e_pi == 3'b001) begin
                chk("route_proc_id", proc_id, e_id);
                chk("route_proc_good", proc_good, e_g);
                chk("route_proc_bad", proc_bad, e_b);
            end
            if (r == nres) break;
            v = (force_min && r == 0) ? 1'b1 : 1'($urandom);
            net_valid = v;
            if (force_min && r == 0) begin
                net_target_id = 2'd0; net_good = 4'h8; net_bad = 4'h2;
            end else begin
                net_target_id = 2'($urandom); net_good = 4'($urandom); net_bad = 4'($urandom);
            end
            if (v) begin
                e_pi = 3'b001; e_id = net_target_id;
                e_g = exp_tok(net_good, sgn); e_b = exp_tok(net_bad, sgn);
            end else begin
                e_pi = 3'b000;
            end
            tick();
        end
        net_done = 1'b1;
        net_valid = 1'($urandom);
        tick();
        net_done = 1'b0; net_valid = 1'b0;
        chk("done_stage", stage, 2'b10);
        chk("done_net", net_instr, 3'b000);
        chk("done_proc", proc_instr, 3'b000);
    endtask

    // Deliver all pending events; abort resets the DUT mid-ROUTE of the first.
    task automatic drain(input int first_delay, input bit force_min, input bit abort);
        bit first_evt;
        int id;
        logic [1:0] s;
        int d;
        first_evt = 1'b1;
        while (q_id.size() > 0) begin
            id = q_id[0];
            s = q_ss[0];
            chk("drain_stage", stage, 2'b10);
            chk("ev_valid", ev_valid, 1'b1);
            chk("ev_id", ev_id, id);
            chk("ev_ss", ev_startstop, s);
            chk("drain_overflow", overflow, exp_ovf);
            d = (first_evt && first_delay >= 0) ? first_delay : $urandom_range(0, 2);
            for (int k = 0; k < d; k++) begin
                ev_ready = 1'b0;
                tick();
                chk("hold_valid", ev_valid, 1'b1);
                chk("hold_id", ev_id, id);
                chk("hold_ss", ev_startstop, s);
                chk("hold_stage", stage, 2'b10);
            end
            ev_ready = 1'b1;
            tick();
            ev_ready = 1'b0;
            void'(q_id.pop_front());
            void'(q_ss.pop_front());
            chk("pop_stage", stage, 2'b11);
            chk("pop_ev_valid", ev_valid, 1'b0);
            chk("pop_net_instr", net_instr, 3'b010);
            chk("pop_net_src", net_source_id, id);
            if (abort) begin
                net_valid = 1'b0; net_done = 1'b0;
                tick();
                chk("abort_pre_net", net_instr, 3'b011);
                reset = 1'b1;
                net_valid = 1'b1;
                tick();
                reset = 1'b0;
                net_valid = 1'b0;
                q_id.delete();
                q_ss.delete();
                exp_ovf = 1'b0;
                chk_reset_state();
                return;
            end
            route_one(s[1], force_min && s == 2'b01);
            first_evt = 1'b0;
        end
        chk("empty_stage", stage, 2'b10);
        chk("empty_ev_valid", ev_valid, 1'b0);
        tick();
        chk("back_idle_stage", stage, 2'b00);
        chk("back_idle_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd = 2'b00; in_id = 2'b00; in_good = 4'h0; in_bad = 4'h0;
        proc_startstop = 2'b00; net_done = 1'b0; net_valid = 1'b0;
        net_target_id = 2'b00; net_good = 4'h0; net_bad = 4'h0; ev_ready = 1'b0;
        tick();
        tick();
        do_reset();

        inject(2'd2, 4'h3, 4'hF);
        cmd = 2'b11;
        tick();
        cmd = 2'b00;
        chk("cmd11_instr", proc_instr, 3'b000);
        chk("cmd11_stage", stage, 2'b00);

        // p1 start, p3 stop (p2 reports 11, discarded); first event held 5 cycles.
        do_step(8'b01_11_10_00);
        drain(5, 1'b1, 1'b0);

        // Three events into a 2-deep FIFO.
        do_step(8'b00_10_01_10);
        drain(-1, 1'b0, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        do_reset();

        // Reset mid-ROUTE loses the second pending event.
        do_step(8'b01_11_10_00);
        drain(-1, 1'b0, 1'b1);
        do_step(8'b00_00_00_00);
        drain(-1, 1'b0, 1'b0);

        for (int round = 0; round < 30; round++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            repeat ($urandom_range(0, 2)) inject(2'($urandom), 4'($urandom), 4'($urandom));
            do_step(8'($urandom));
            drain(-1, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_jleugeri_ttt_scheduler.md
TT_UM_JLEUGERI_TTT_SCHEDULER -- requirements
Module: tt_um_jleugeri_ttt_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 16: number of processor contexts; PW = $clog2(NUM_PROCESSORS).
REQ-002 SHALL have parameter NEW_TOKEN_BITS, default 4: signed token-delta width B.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two: depth of the event FIFO.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock_fast  in  1  sole clock, all logic on posedge; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have cmd  in  2  host command: 00 idle, 01 inject, 10 step, 11 reserved (no-op); cmd_ready  out  1  high only in IDLE.
REQ-006 SHALL have in_id  in  PW, in_good/in_bad  in  B signed: injection target and token deltas.
REQ-007 SHALL have proc_instr  out  3, proc_id  out  PW, proc_good/proc_bad  out  B signed: processor-core command bus; proc_startstop  in  2: {start,stop} for the processor updated one cycle earlier.
REQ-008 SHALL have net_instr  out  3, net_source_id  out  PW: network command; net_done, net_valid  in  1; net_target_id  in  PW; net_good/net_bad  in  B signed.
REQ-009 SHALL have ev_valid  out  1, ev_ready  in  1, ev_id  out  PW, ev_startstop  out  2: host event stream; stage  out  2: current state; overflow  out  1: sticky FIFO-drop flag.

Function
REQ-010 SHALL implement states IDLE=00, UPDATE=01, DRAIN=10, ROUTE=11, reported on stage.
REQ-011 IDLE: cmd=01 SHALL drive next cycle proc_instr=001, proc_id=in_id, proc_good/bad=in_good/bad; cmd=00/11 SHALL drive proc_instr=000; cmd=10 SHALL enter UPDATE with index i=0; commands outside IDLE are ignored.
REQ-012 UPDATE: for i=0..N-1 SHALL issue proc_instr=010, proc_id=i, proc_good/bad=0, one processor per cycle; cycle N SHALL issue proc_instr=000.
REQ-013 UPDATE: in cycles 1..N, if proc_startstop is 10 or 01, SHALL push {i-1, proc_startstop} into the FIFO; 00 and 11 SHALL be discarded; after cycle N SHALL enter DRAIN (UPDATE lasts exactly N+1 cycles).
REQ-014 Push with FIFO full SHALL drop the event and set overflow, which stays set until reset.
REQ-015 DRAIN: FIFO empty SHALL return to IDLE; otherwise ev_valid=1 with head on ev_id/ev_startstop, held stable while ev_ready=0.
REQ-016 On ev_valid&&ev_ready SHALL pop, latch sign=ev_startstop[1], drive net_source_id=ev_id, net_instr=010 and enter ROUTE; ev_valid SHALL be 0 in every other state.
REQ-017 ROUTE: first cycle SHALL ignore net_valid; subsequent cycles SHALL drive net_instr=011 until net_done.
REQ-018 ROUTE: net_valid (not first cycle) SHALL drive next cycle proc_instr=001, proc_id=net_target_id, proc_good/bad = net value if sign=1, negated value if sign=0; else proc_instr=000.
REQ-019 Negation SHALL saturate: -(-2^(B-1)) yields 2^(B-1)-1 (B=4: -(-8)=+7).
REQ-020 net_done SHALL drive net_instr=000, proc_instr=000 next cycle and return to DRAIN; net_done on the first ROUTE cycle SHALL also be honoured.
REQ-021 FIFO SHALL preserve ascending processor order; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-022 Reset SHALL force state IDLE, FIFO empty, overflow=0, ev_valid=0, all instr/id/token outputs 0, cmd_ready=1 the cycle after reset.
REQ-023 Reset in any state, including mid-ROUTE, SHALL abandon the operation; pending events are lost.

Configuration
REQ-024 Macro TTT_SCHED_EVENT_COUNT_EN defined: SHALL add output event_count  out  16, counting ev handshakes, saturating at 0xFFFF, cleared by reset.
REQ-025 Macro undefined: event_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 N=4; reset, cmd=01, in_id=2, in_good=3, in_bad=-1 -> next cycle proc_instr=001, proc_id=2, proc_good=3, proc_bad=-1.
REQ-027 cmd=10, proc_startstop 10 after proc 1 and 01 after proc 3 -> stage 01 for 5 cycles; events (1,10) then (3,01) on ev stream.
REQ-028 ev_ready low 5 cycles -> ev_id/ev_startstop stable, ev_valid high; raising ev_ready -> one pop, net_instr=010, net_source_id=1.
REQ-029 Stop event, net_valid with target 0, net_good=-8, net_bad=2 -> proc_good=+7, proc_bad=-2, proc_id=0; net_done -> stage 10, then 00 when empty.
REQ-030 FIFO_DEPTH=2, three events in one UPDATE -> first two delivered in order, overflow=1 until reset.
REQ-031 Reset asserted mid-ROUTE -> next cycle stage=00, net_instr=000, ev_valid=0, FIFO empty; with TTT_SCHED_EVENT_COUNT_EN, event_count=0.
